// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state types and UART_CON status bit positions.
// Defining UART_PARITY_EN adds the PARITY state and even-parity helper for 8E1 frames.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int CNT_W      = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_DONE  = 1;
    localparam int ST_RX_READY = 2;
    localparam int ST_RX_OVR   = 3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: emits a one-clock tick every DIV clocks; this is the oversampling
// tick shared by the TX and RX engines.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_baud_gen: DIV must be at least 1");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_controller.sv
// uart_controller: 8N1 UART engine behind UART_TXD / UART_RXD / UART_CON (8E1 when
// UART_PARITY_EN is defined). TX and RX are independent FSMs on one shared baud tick.
module uart_controller
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       rx_ack,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic [3:0] status
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

    logic tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Handshakes: tx_start is taken only in a cycle where tx_busy is low (otherwise
    // dropped); rx_ready holds until an rx_ack pulse, and a byte completing in the
    // same cycle as rx_ack wins.

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_done, tx_done_nxt;
    logic             tx_line, tx_line_nxt;
    logic             tx_busy;
`ifdef UART_PARITY_EN
    logic             tx_par, tx_par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_done  <= tx_done_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_par <= 1'b0;
        end else begin
            tx_par <= tx_par_nxt;
        end
    end
`endif

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_done_nxt  = tx_done;
        tx_line_nxt  = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = tx_data;
                    tx_done_nxt  = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = even_parity(tx_data);
`endif
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state_nxt = TX_DATA;
                        tx_cnt_nxt   = '0;
                        tx_bit_nxt   = '0;
                    end else begin
                        tx_cnt_nxt = tx_cnt + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt_nxt   = '0;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_bit_nxt   = tx_bit + 1'b1;
                        if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_state_nxt = TX_PARITY;
`else
                            tx_state_nxt = TX_STOP;
`endif
                        end
                    end else begin
                        tx_cnt_nxt = tx_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state_nxt = TX_STOP;
                        tx_cnt_nxt   = '0;
                    end else begin
                        tx_cnt_nxt = tx_cnt + 1'b1;
                    end
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state_nxt = TX_IDLE;
                        tx_cnt_nxt   = '0;
                        tx_done_nxt  = 1'b1;
                    end else begin
                        tx_cnt_nxt = tx_cnt + 1'b1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase

        // Line level follows the next state so uart_tx leaves a flop, glitch-free.
        case (tx_state_nxt)
            TX_START:  tx_line_nxt = 1'b0;
            TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_line_nxt = tx_par_nxt;
`endif
            default:   tx_line_nxt = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE);
    assign uart_tx = tx_line;

    logic             rx_s1, rx_in, rx_prev;
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_good;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic             rx_ready, rx_ready_nxt;
    logic             rx_ovr, rx_ovr_nxt;
`ifdef UART_PARITY_EN
    logic             rx_perr, rx_perr_nxt;
`endif

    // Synchroniser flops reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_in    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_ready <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_in    <= rx_s1;
            rx_prev  <= rx_in;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_byte  <= rx_byte_nxt;
            rx_ready <= rx_ready_nxt;
            rx_ovr   <= rx_ovr_nxt;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_perr <= 1'b0;
        end else begin
            rx_perr <= rx_perr_nxt;
        end
    end
`endif

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_good      = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_nxt  = rx_perr;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_in) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Mid-start re-check; a high line here was only a glitch.
                if (tick) begin
                    if (rx_cnt == CNT_MID) begin
                        rx_state_nxt = rx_in ? RX_IDLE : RX_DATA;
                        rx_cnt_nxt   = '0;
                        rx_bit_nxt   = '0;
                    end else begin
                        rx_cnt_nxt = rx_cnt + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt_nxt   = '0;
                        rx_shift_nxt = {rx_in, rx_shift[7:1]};
                        rx_bit_nxt   = rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state_nxt = RX_PARITY;
`else
                            rx_state_nxt = RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt_nxt = rx_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_state_nxt = RX_STOP;
                        rx_cnt_nxt   = '0;
                        rx_perr_nxt  = rx_in ^ even_parity(rx_shift);
                    end else begin
                        rx_cnt_nxt = rx_cnt + 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_state_nxt = RX_IDLE;
                        rx_cnt_nxt   = '0;
`ifdef UART_PARITY_EN
                        rx_good      = rx_in & ~rx_perr;
`else
                        rx_good      = rx_in;
`endif
                    end else begin
                        rx_cnt_nxt = rx_cnt + 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_byte_nxt  = rx_byte;
        rx_ready_nxt = rx_ready & ~rx_ack;
        rx_ovr_nxt   = rx_ovr & ~rx_ack;
        if (rx_good) begin
            rx_byte_nxt  = rx_shift;
            rx_ready_nxt = 1'b1;
            if (rx_ready && !rx_ack) begin
                rx_ovr_nxt = 1'b1;
            end
        end
    end

    assign rx_data             = rx_byte;
    assign status[ST_TX_BUSY]  = tx_busy;
    assign status[ST_TX_DONE]  = tx_done;
    assign status[ST_RX_READY] = rx_ready;
    assign status[ST_RX_OVR]   = rx_ovr;

endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: randomized self-checking bench for uart_controller at 16 clk/bit.
// Frames are modelled as bit vectors built from the byte; status follows a small model.
`timescale 1ns/1ps
module tb_uart_controller;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    localparam int FRAME_CLKS = NBITS * BIT_CLKS;
    // Byte lands at mid-stop; allow a few clocks for synchroniser and edge detect.
    localparam int LAT_MIN = (NBITS - 1) * BIT_CLKS + BIT_CLKS / 2;
    localparam int LAT_MAX = LAT_MIN + 6;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       rx_ack   = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic [3:0] status;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_data = 8'h00;
    logic       exp_ready   = 1'b0;
    logic       exp_ovr     = 1'b0;
    int         rx_lat      = LAT_MIN + 3;
    int         dummy;

    uart_controller #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .rx_ack   (rx_ack),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .rx_data  (rx_data),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Bit 0 is the start bit; line bit i is held for BIT_CLKS clocks.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop_bit);
`ifdef UART_PARITY_EN
        frame_bits = {stop_bit, ^d, d, 1'b0};
`else
        frame_bits = {1'b1, stop_bit, d, 1'b0};
`endif
    endfunction

    task automatic do_tx_frame(input logic [7:0] d, input int inject_at, input int tail);
        logic [10:0] fb;
        logic        exp_bit;
        fb = frame_bits(d, 1'b1);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        total++;
        if (status[1] !== 1'b0) begin
            bad++;
            $display("FAIL tx_done_clear: got %b want 0", status[1]);
        end
        for (int k = 0; k < FRAME_CLKS; k++) begin
            exp_bit = fb[4'(k / BIT_CLKS)];
            total++;
            if (uart_tx !== exp_bit) begin
                bad++;
                $display("FAIL tx_bit: byte %h cycle %0d got %b want %b", d, k, uart_tx, exp_bit);
            end
            total++;
            if (status[0] !== 1'b1) begin
                bad++;
                $display("FAIL tx_busy: byte %h cycle %0d got %b want 1", d, k, status[0]);
            end
            if (k == inject_at) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        total++;
        if (status[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL tx_end: byte %h done/busy got %b want 10", d, status[1:0]);
        end
        total++;
        if (uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL tx_idle: got %b want 1", uart_tx);
        end
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            total++;
            if ({uart_tx, status[0]} !== 2'b10) begin
                bad++;
                $display("FAIL tx_quiet: cycle %0d line/busy got %b want 10", k, {uart_tx, status[0]});
            end
        end
    endtask

    task automatic do_rx_frame(input logic [7:0] d, input logic stop_bit, input int ack_at,
                               output int rise);
        logic [10:0] fb;
        logic        was_rdy;
        logic [7:0]  want;
        fb      = frame_bits(d, stop_bit);
        was_rdy = status[2];
        rise    = -1;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            if (rise < 0 && !was_rdy && status[2] === 1'b1) rise = k;
            uart_rx = fb[4'(k / BIT_CLKS)];
            rx_ack  = (k == ack_at);
            @(negedge clk);
        end
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        if (rise < 0 && !was_rdy && status[2] === 1'b1) rise = FRAME_CLKS;
        repeat (4) @(negedge clk);
        if (stop_bit) begin
            exp_q.push_back(d);
            if (ack_at >= 0) exp_ovr = 1'b0;
            else if (exp_ready) exp_ovr = 1'b1;
            exp_ready   = 1'b1;
            exp_rx_data = exp_q.pop_front();
        end else if (ack_at >= 0) begin
            exp_ready = 1'b0;
            exp_ovr   = 1'b0;
        end
        want = exp_rx_data;
        total++;
        if (rx_data !== want) begin
            bad++;
            $display("FAIL rx_data: frame %h stop %b got %h want %h", d, stop_bit, rx_data, want);
        end
        total++;
        if (status[3:2] !== {exp_ovr, exp_ready}) begin
            bad++;
            $display("FAIL rx_status: frame %h got %b want %b", d, status[3:2], {exp_ovr, exp_ready});
        end
    endtask

    task automatic do_rx_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack    = 1'b0;
        exp_ready = 1'b0;
        exp_ovr   = 1'b0;
        total++;
        if (status[3:2] !== 2'b00) begin
            bad++;
            $display("FAIL rx_ack_clear: got %b want 00", status[3:2]);
        end
        total++;
        if (rx_data !== exp_rx_data) begin
            bad++;
            $display("FAIL rx_ack_hold: got %h want %h", rx_data, exp_rx_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b want 1", uart_tx);
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        total++;
        if (status !== 4'b0000) begin
            bad++;
            $display("FAIL reset_status: got %b want 0000", status);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_basic();
        do_tx_frame(8'h55, -1, 0);
    endtask

    task automatic test_tx_ignore();
        do_tx_frame(8'h55, 50, 40);
    endtask

    task automatic test_rx_basic();
        int rise;
        do_rx_frame(8'hA3, 1'b1, -1, rise);
        total++;
        if (rise < LAT_MIN || rise > LAT_MAX) begin
            bad++;
            $display("FAIL rx_latency: got %0d want %0d..%0d", rise, LAT_MIN, LAT_MAX);
        end else begin
            rx_lat = rise;
        end
        do_rx_ack();
    endtask

    task automatic test_rx_overrun();
        do_rx_frame(8'h11, 1'b1, -1, dummy);
        do_rx_frame(8'h22, 1'b1, -1, dummy);
        do_rx_ack();
    endtask

    task automatic test_rx_errors();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (status[3:2] !== {exp_ovr, exp_ready} || rx_data !== exp_rx_data) begin
            bad++;
            $display("FAIL rx_glitch: status %b data %h want %b %h",
                     status[3:2], rx_data, {exp_ovr, exp_ready}, exp_rx_data);
        end
        do_rx_frame(8'($urandom_range(0, 255)), 1'b0, -1, dummy);
        do_rx_frame(8'($urandom_range(0, 255)), 1'b1, -1, dummy);
    endtask

    task automatic test_ack_collision();
        // rx_ready is already set; the ack lands on the completion edge.
        do_rx_frame(8'($urandom_range(0, 255)), 1'b1, rx_lat - 1, dummy);
        do_rx_ack();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_rx_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0), -1, dummy);
            if ($urandom_range(0, 1) == 1) do_rx_ack();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            do_tx_frame(8'($urandom_range(0, 255)), -1, 0);
        end
    endtask

    task automatic test_simultaneous();
        fork
            do_tx_frame(8'($urandom_range(0, 255)), -1, 0);
            do_rx_frame(8'($urandom_range(0, 255)), 1'b1, -1, dummy);
        join
    endtask

    task automatic test_reset_mid_frame();
        do_rx_frame(8'($urandom_range(0, 255)), 1'b1, -1, dummy);
        tx_data  = 8'($urandom_range(0, 255));
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_ready   = 1'b0;
        exp_ovr     = 1'b0;
        exp_rx_data = 8'h00;
        total++;
        if (uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL midreset_tx: got %b want 1", uart_tx);
        end
        total++;
        if (status !== 4'b0000 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_state: status %b data %h want 0000 00", status, rx_data);
        end
        reset    = 1'b0;
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        total++;
        if ({status[0], uart_tx} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_accept: busy/line got %b want 10", {status[0], uart_tx});
        end
        repeat (FRAME_CLKS) @(negedge clk);
        total++;
        if (status[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_done: got %b want 10", status[1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_ignore();
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
        test_ack_collision();
        test_random();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
